drop_controller: RTL and testbench

- Owns the position of the active falling piece: spawns it, steps it down under gravity, and shifts it left and right on request.
- Drives ref_x/ref_y to the bottom-contact detector and consumes that detector's stop flag.
- Runs a lock-delay timer once the piece rests, then emits a one-cycle lock pulse to the game logic and goes idle.
- Sits between the frame timing / input logic and the collision / grid-merge logic.

---
 rtl/drop_controller.sv | 154 +++++++++++++++
 tb/tb_drop_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/drop_controller.sv
// Falling-piece position controller: spawns a piece, applies gravity and
// horizontal shifts, then runs a lock delay before committing the piece.
module drop_controller #(
  parameter int SIZE       = 16,
  parameter int BOTTOM     = 480,
  parameter int X_MIN      = 240,
  parameter int X_MAX      = 384,
  parameter int SPAWN_X    = 304,
  parameter int SPAWN_Y    = 0,
  parameter int GRAV_TICKS = 25,
  parameter int LOCK_TICKS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       soft_drop,
  input  logic       stop,
  output logic [9:0] ref_x,
  output logic [9:0] ref_y,
  output logic       active,
  output logic       lock
);

  localparam int GW = (GRAV_TICKS > 1) ? $clog2(GRAV_TICKS) : 1;
  localparam int LW = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;

  localparam logic [9:0]    L_STEP      = 10'(SIZE);
  localparam logic [9:0]    L_FLOOR     = 10'(BOTTOM - SIZE);
  localparam logic [9:0]    L_LEFT_OK   = 10'(X_MIN + SIZE);
  localparam logic [9:0]    L_RIGHT_OK  = 10'(X_MAX - SIZE);
  localparam logic [9:0]    L_SPAWN_X   = 10'(SPAWN_X);
  localparam logic [9:0]    L_SPAWN_Y   = 10'(SPAWN_Y);
  localparam logic [GW-1:0] L_GRAV_LAST = GW'(GRAV_TICKS - 1);
  localparam logic [LW-1:0] L_LOCK_LAST = LW'(LOCK_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FALL,
    S_LOCK_WAIT,
    S_LOCKED
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grav_cnt, w_grav_cnt_nxt;
  logic [LW-1:0]   r_lock_cnt, w_lock_cnt_nxt;
  logic [9:0]      r_ref_x, w_ref_x_nxt;
  logic [9:0]      r_ref_y, w_ref_y_nxt;
  logic            r_active, w_active_nxt;
  logic            r_lock, w_lock_nxt;

  logic            w_blocked;
  logic            w_step;
  logic            w_can_move;

  // The floor term keeps ref_y in range even if the detector misses contact.
  assign w_blocked  = stop || (r_ref_y >= L_FLOOR);
  assign w_step     = frame_tick && (soft_drop || (r_grav_cnt == L_GRAV_LAST));
  assign w_can_move = (r_state == S_FALL) || (r_state == S_LOCK_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grav_cnt <= '0;
      r_lock_cnt <= '0;
      r_ref_x    <= L_SPAWN_X;
      r_ref_y    <= L_SPAWN_Y;
      r_active   <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grav_cnt <= w_grav_cnt_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_ref_x    <= w_ref_x_nxt;
      r_ref_y    <= w_ref_y_nxt;
      r_active   <= w_active_nxt;
      r_lock     <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grav_cnt_nxt = r_grav_cnt;
    w_lock_cnt_nxt = r_lock_cnt;
    w_ref_x_nxt    = r_ref_x;
    w_ref_y_nxt    = r_ref_y;
    w_active_nxt   = r_active;
    w_lock_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (spawn) begin
          w_ref_x_nxt    = L_SPAWN_X;
          w_ref_y_nxt    = L_SPAWN_Y;
          w_grav_cnt_nxt = '0;
          w_lock_cnt_nxt = '0;
          w_active_nxt   = 1'b1;
          w_state_nxt    = S_FALL;
        end
      end
      S_FALL: begin
        if (w_step) begin
          w_grav_cnt_nxt = '0;
          if (!w_blocked) begin
            w_ref_y_nxt = r_ref_y + L_STEP;
          end else begin
            w_lock_cnt_nxt = '0;
            w_state_nxt    = S_LOCK_WAIT;
          end
        end else if (frame_tick) begin
          w_grav_cnt_nxt = r_grav_cnt + 1'b1;
        end
      end
      S_LOCK_WAIT: begin
        if (frame_tick) begin
          if (!w_blocked) begin
            w_grav_cnt_nxt = '0;
            w_lock_cnt_nxt = '0;
            w_state_nxt    = S_FALL;
          end else if (r_lock_cnt == L_LOCK_LAST) begin
            w_lock_nxt   = 1'b1;
            w_active_nxt = 1'b0;
            w_state_nxt  = S_LOCKED;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + 1'b1;
          end
        end
      end
      S_LOCKED: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Conflicting left+right requests cancel each other out.
    if (w_can_move && (move_left ^ move_right)) begin
      if (move_left && (r_ref_x >= L_LEFT_OK)) begin
        w_ref_x_nxt = r_ref_x - L_STEP;
      end else if (move_right && (r_ref_x <= L_RIGHT_OK)) begin
        w_ref_x_nxt = r_ref_x + L_STEP;
      end
    end
  end

  assign ref_x  = r_ref_x;
  assign ref_y  = r_ref_y;
  assign active = r_active;
  assign lock   = r_lock;

endmodule

// File: tb/tb_drop_controller.sv
// Directed testbench for drop_controller: gravity, moves, lock delay,
// lock-wait escape and asynchronous reset abort.
module tb_drop_controller;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       spawn;
  logic       move_left;
  logic       move_right;
  logic       soft_drop;
  logic       stop;
  logic [9:0] ref_x;
  logic [9:0] ref_y;
  logic       active;
  logic       lock;

  logic       stopForce;
  logic       stopVal;
  int         vectors;
  int         miscompares;
  int         lockCount;

  drop_controller dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .spawn      (spawn),
    .move_left  (move_left),
    .move_right (move_right),
    .soft_drop  (soft_drop),
    .stop       (stop),
    .ref_x      (ref_x),
    .ref_y      (ref_y),
    .active     (active),
    .lock       (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bottom-contact detector model, overridable for directed corner cases.
  assign stop = stopForce ? stopVal : ((ref_y + 10'd16) == 10'd480);

  always @(negedge clk) begin
    if (lock === 1'b1) lockCount++;
  end

  task automatic applyStimulus(input logic ft, input logic sp,
                               input logic ml, input logic mr);
    @(negedge clk);
    frame_tick = ft;
    spawn      = sp;
    move_left  = ml;
    move_right = mr;
    @(negedge clk);
    frame_tick = 1'b0;
    spawn      = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    lockCount   = 0;
    stopForce   = 1'b0;
    stopVal     = 1'b0;
    reset       = 1'b1;
    frame_tick  = 1'b0;
    spawn       = 1'b0;
    move_left   = 1'b0;
    move_right  = 1'b0;
    soft_drop   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_x", ref_x, 304);
    checkOutput("rst_y", ref_y, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_lock", lock, 0);
    reset = 1'b0;

    // Ticks in IDLE do nothing
    ticks(30);
    checkOutput("idle_y", ref_y, 0);
    checkOutput("idle_active", active, 0);

    // Spawn and normal gravity
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("spawn_active", active, 1);
    checkOutput("spawn_x", ref_x, 304);
    ticks(24);
    checkOutput("grav24_y", ref_y, 0);
    ticks(1);
    checkOutput("grav25_y", ref_y, 16);
    ticks(25);
    checkOutput("grav50_y", ref_y, 32);

    // Spawn while falling is ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("spawn_ign_y", ref_y, 32);
    checkOutput("spawn_ign_x", ref_x, 304);

    // Horizontal moves and limits
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("left4_x", ref_x, 240);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("left_cap_x", ref_x, 240);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("right_cap_x", ref_x, 384);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("both_x", ref_x, 384);

    // Soft drop down to the floor; floor alone blocks even with stop low
    soft_drop = 1'b1;
    ticks(27);
    checkOutput("floor_y", ref_y, 464);
    stopForce = 1'b1;
    stopVal   = 1'b0;
    ticks(1);
    checkOutput("block_y", ref_y, 464);
    checkOutput("block_active", active, 1);
    soft_drop = 1'b0;

    // Lock delay, with a move midway that must not restart it
    ticks(7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lw_move_x", ref_x, 368);
    ticks(7);
    checkOutput("lw14_lock", lock, 0);
    checkOutput("lw14_active", active, 1);
    ticks(1);
    checkOutput("lock_pulse", lock, 1);
    checkOutput("lock_active", active, 0);
    checkOutput("lock_y", ref_y, 464);
    @(negedge clk);
    checkOutput("lock_end", lock, 0);
    checkOutput("lock_count1", lockCount, 1);
    ticks(20);
    checkOutput("hold_y", ref_y, 464);
    checkOutput("hold_x", ref_x, 368);
    checkOutput("lock_count2", lockCount, 1);
    stopForce = 1'b0;

    // Respawn, soft drop then normal gravity resumes from grav_cnt 0
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("respawn_x", ref_x, 304);
    checkOutput("respawn_y", ref_y, 0);
    soft_drop = 1'b1;
    ticks(3);
    checkOutput("soft3_y", ref_y, 48);
    soft_drop = 1'b0;
    ticks(24);
    checkOutput("soft_rel24_y", ref_y, 48);
    ticks(1);
    checkOutput("soft_rel25_y", ref_y, 64);

    // Enter LOCK_WAIT via stop, then escape back to FALL
    stopForce = 1'b1;
    stopVal   = 1'b1;
    soft_drop = 1'b1;
    ticks(1);
    checkOutput("lw_enter_y", ref_y, 64);
    soft_drop = 1'b0;
    ticks(7);
    stopVal = 1'b0;
    ticks(1);
    checkOutput("escape_y", ref_y, 64);
    checkOutput("escape_active", active, 1);
    checkOutput("escape_lock", lock, 0);
    stopForce = 1'b0;
    ticks(24);
    checkOutput("escape24_y", ref_y, 64);
    ticks(1);
    checkOutput("escape25_y", ref_y, 80);
    checkOutput("escape_count", lockCount, 1);

    // Asynchronous reset mid-fall
    soft_drop = 1'b1;
    ticks(3);
    checkOutput("pre_rst_y", ref_y, 128);
    soft_drop = 1'b0;
    #3 reset = 1'b1;
    #1;
    checkOutput("arst_y", ref_y, 0);
    checkOutput("arst_x", ref_x, 304);
    checkOutput("arst_active", active, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ticks(40);
    checkOutput("arst_count", lockCount, 1);
    checkOutput("arst_idle_y", ref_y, 0);

    // Normal operation after reset
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_spawn_active", active, 1);
    ticks(25);
    checkOutput("post_grav_y", ref_y, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
